// File: rtl/mul_arbiter.sv
// Two-requester 4x4 unsigned multiplier with a valid/ready arbiter in front of a
// three-state IDLE/CALC/DONE sequencer. Optional macro MUL_ARB_RR_EN selects
// round-robin arbitration; without it port 0 has fixed priority.
// The product is registered one cycle before DONE is entered, so res_valid rises
// CALC_CYCLES+1 edges after the accept edge.
module mul_arbiter #(
  parameter int unsigned CALC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy
);

  localparam logic [3:0] CntLoad = 4'(CALC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       id_q, id_d;
  logic       loaded_q, loaded_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_id_q, res_id_d;

  logic gnt_id;
  logic any_valid;
  logic in_idle;
  logic accept;

  assign any_valid = req0_valid | req1_valid;

`ifdef MUL_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Round-robin: on contention grant the port that did not win last time.
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = ~req0_valid;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it is valid.
  always_comb begin
    gnt_id = ~req0_valid;
  end
`endif

  // Ready is gated by reset so nothing looks accepted while rst_n is low.
  assign in_idle    = (state_q == StIdle) && rst_n;
  assign req0_ready = in_idle && any_valid && !gnt_id;
  assign req1_ready = in_idle && any_valid && gnt_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign res_valid = (state_q == StDone);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != StIdle);

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    loaded_d   = loaded_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
`ifdef MUL_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d      = gnt_id ? req1_a : req0_a;
          b_d      = gnt_id ? req1_b : req0_b;
          id_d     = gnt_id;
          cnt_d    = CntLoad;
          loaded_d = 1'b0;
          state_d  = StCalc;
`ifdef MUL_ARB_RR_EN
          last_grant_d = gnt_id;
`endif
        end
      end
      StCalc: begin
        if (loaded_q) begin
          loaded_d = 1'b0;
          state_d  = StDone;
        end else if (cnt_q == 4'd0) begin
          res_data_d = {4'b0000, a_q} * {4'b0000, b_q};
          res_id_d   = id_q;
          loaded_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      id_q       <= 1'b0;
      loaded_q   <= 1'b0;
      res_data_q <= 8'd0;
      res_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      loaded_q   <= loaded_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

`ifdef MUL_ARB_RR_EN
  // Last-grant register; reset to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule
